// File: rtl/remapper_bucket.sv
// remapper_bucket: maps an unsigned magnitude to a clamped LED bucket index
// by counting the STEP-spaced thresholds it reaches.
`timescale 1ns/1ps
`default_nettype none

module remapper_bucket #(
   parameter int IN_W = 16,
   parameter int HALF = 5,
   parameter int STEP = 20,
   parameter int BW   = (HALF > 1) ? $clog2(HALF) : 1
) (
   input  logic [IN_W-1:0] abs_i,
   output logic [BW-1:0]   bucket_o
);

   logic [BW-1:0] cnt_w;

   // Thresholds are k*STEP for k = 1..HALF-1; no divider needed.
   always_comb begin
      cnt_w = '0;
      for (int k = 1; k < HALF; k++) begin
         if (32'(abs_i) >= 32'(k * STEP))
            cnt_w = cnt_w + BW'(1);
      end
   end

   assign bucket_o = cnt_w;

endmodule

`default_nettype wire

// File: rtl/remapper.sv
// remapper: registered magnitude, sign flag and one-hot LED position
// derived from a signed sample, one cycle of latency.
`timescale 1ns/1ps
`default_nettype none

module remapper #(
   parameter int IN_W = 16,
   parameter int LEDS = 10,
   parameter int STEP = 20
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] in,
   output logic [IN_W-1:0] abs_in,
   output logic            neg,
   output logic [LEDS-1:0] board_posit
);

   localparam int HALF = LEDS / 2;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [LEDS-1:0] POS_RST  = LEDS'(1) << HALF;
   localparam logic [IN_W-1:0] MIN_NEG  = {1'b1, {(IN_W-1){1'b0}}};
   localparam logic [IN_W-1:0] MAX_POS  = {1'b0, {(IN_W-1){1'b1}}};

   logic            neg_d, neg_q;
   logic [IN_W-1:0] abs_d, abs_q;
   logic [LEDS-1:0] pos_d, pos_q;
   logic [IN_W-1:0] in_negated;
   logic [BW-1:0]   bucket;
   int              led_idx;

   assign neg_d      = in[IN_W-1];
   assign in_negated = -in;

   // The most negative sample has no positive counterpart, so it saturates.
   always_comb begin
      abs_d = in;
      if (neg_d)
         abs_d = (in == MIN_NEG) ? MAX_POS : in_negated;
   end

   remapper_bucket #(
      .IN_W (IN_W),
      .HALF (HALF),
      .STEP (STEP),
      .BW   (BW)
   ) u_bucket (
      .abs_i    (abs_d),
      .bucket_o (bucket)
   );

   // Negative values grow leftwards from HALF-1, non-negative rightwards from HALF.
   always_comb begin
      led_idx = neg_d ? (HALF - 1 - int'(bucket)) : (HALF + int'(bucket));
      pos_d   = LEDS'(1) << led_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         abs_q <= '0;
         neg_q <= 1'b0;
         pos_q <= POS_RST;
      end else begin
         abs_q <= abs_d;
         neg_q <= neg_d;
         pos_q <= pos_d;
      end
   end

   assign abs_in      = abs_q;
   assign neg         = neg_q;
   assign board_posit = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_remapper.sv
// tb_remapper: directed and random self-checking bench for remapper.
`timescale 1ns/1ps
`default_nettype none

module tb_remapper;

   logic        clk;
   logic        rst;
   logic [15:0] din;
   logic [15:0] abs_in;
   logic        neg;
   logic [9:0]  board_posit;

   int n_tests;
   int n_fail;

   remapper dut (
      .clk         (clk),
      .rst         (rst),
      .in          (din),
      .abs_in      (abs_in),
      .neg         (neg),
      .board_posit (board_posit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] led(input int b);
      logic [9:0] v;
      v = 10'd1;
      return v << b;
   endfunction

   // Apply a sample, then sample outputs just after the capturing edge.
   task automatic step(input int v);
      din = 16'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input int a, input logic n, input int b);
      check({tag, "_abs"}, 32'(abs_in), 32'(a));
      check({tag, "_neg"}, 32'(neg), 32'(n));
      check({tag, "_pos"}, 32'(board_posit), 32'(led(b)));
   endtask

   int vin  [18] = '{85, 65, 45, 25, 5, -15, -35, -55, -75, -95,
                     19, 20, -19, -20, 0, -32768, 32767, -1};
   int vabs [18] = '{85, 65, 45, 25, 5, 15, 35, 55, 75, 95,
                     19, 20, 19, 20, 0, 32767, 32767, 1};
   int vneg [18] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1,
                     0, 0, 1, 1, 0, 1, 0, 1};
   int vbit [18] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0,
                     5, 6, 4, 3, 5, 0, 9, 4};

   initial begin
      int sv, ea, eb, ebit;
      logic en;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      din = 16'd85;
      #1;
      expect_out("rst_init", 0, 1'b0, 5);
      repeat (2) @(posedge clk);
      #1;
      expect_out("rst_hold", 0, 1'b0, 5);
      rst = 1'b0;
      step(85);
      expect_out("rst_rel", 85, 1'b0, 9);

      for (int i = 0; i < 18; i++) begin
         step(vin[i]);
         expect_out($sformatf("vec%0d", i), vabs[i], vneg[i][0], vbit[i]);
      end

      // Asynchronous reset mid-cycle, with outputs holding a non-reset value.
      step(-55);
      expect_out("pre_arst", 55, 1'b1, 2);
      din = 16'd85;
      #2;
      rst = 1'b1;
      #1;
      expect_out("arst", 0, 1'b0, 5);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("arst_hold_abs", 32'(abs_in), 32'd0);
      step(85);
      expect_out("arst_rel", 85, 1'b0, 9);

      for (int i = 0; i < 10000; i++) begin
         sv = int'($signed(16'($urandom)));
         step(sv);
         en = (sv < 0);
         ea = en ? -sv : sv;
         if (ea > 32767) ea = 32767;
         eb = ea / 20;
         if (eb > 4) eb = 4;
         ebit = en ? 4 - eb : 5 + eb;
         check("rnd_onehot", 32'($countones(board_posit)), 32'd1);
         expect_out($sformatf("rnd%0d", i), ea, en, ebit);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/remapper.md
Name: remapper

Overview:
- Converts a signed 16-bit tilt/position sample into three outputs:
  - its magnitude,
  - a sign flag,
  - a one-hot 10-LED board position for the arcade game display.
- Sits between the sensor/position datapath and the LED driver.
- All outputs are registered; one cycle of latency.

Parameters:
- IN_W, 16, input and magnitude width.
- LEDS, 10, LED count; must be even. Half the LEDs are for negative values and half for non-negative.
- STEP, 20, magnitude per LED bucket; must be greater than 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  IN_W  signed two's-complement sample.
- abs_in  output  IN_W  registered absolute value of `in`; unsigned.
- neg  output  1  registered sign flag; 1 when `in` < 0.
- board_posit  output  LEDS  registered one-hot LED position; bit 0 is the leftmost (most negative) LED.

Behaviour:
- Reset values while `rst`=1, asserted asynchronously:
  - abs_in = 0
  - neg = 0
  - board_posit = one-hot bit LEDS/2 (10'b00_0010_0000), which matches `in`=0.
- Latency: outputs reflect the `in` value sampled on the previous rising edge. No handshake; a new sample is accepted every cycle.
- neg = in[IN_W-1].
- abs_in:
  - equals `in` when neg=0;
  - equals -in when neg=1;
  - saturates: in = -32768 gives abs_in = 32767 (16'h7FFF), neg=1.
- Bucket index b = min(floor(abs_in / STEP), LEDS/2 - 1).
  - Computed as a count of thresholds k*STEP, k = 1..LEDS/2-1, that abs_in meets or exceeds. No divider.
  - Defaults: 0-19 gives b=0, 20-39 gives 1, 40-59 gives 2, 60-79 gives 3, 80 and above gives 4 (clamped).
- board_posit:
  - when neg=0, exactly one bit set at index LEDS/2 + b;
  - when neg=1, exactly one bit set at index LEDS/2 - 1 - b.
  - Always exactly one-hot; never all-zero after reset.
- abs_in, neg and board_posit are computed from the same sample and update in the same cycle.
- Reset mid-stream: outputs go to reset values immediately. The first sample after `rst` deasserts appears one cycle later.

Decomposition:
- No shared package is required.
- Derived local constants (HALF = LEDS/2 and the threshold table k*STEP) stay local to the module.
- A natural combinational sub-module is `remapper_bucket`: it takes abs_in and produces b via the threshold compares.

Test Plan:
- Reset: assert `rst` with `in`=85 -> abs_in=0, neg=0, board_posit=10'b0000100000 without waiting for a clock edge; release `rst` -> next edge gives abs_in=85, neg=0, board_posit=10'b1000000000.
- Descending sweep: `in` = 85, 65, 45, 25, 5, -15, -35, -55, -75, -95, one per cycle. Expected, each one cycle later:

  | in | abs_in | board_posit bit set |
  |---|---|---|
  | 85 | 85 | 9 |
  | 65 | 65 | 8 |
  | 45 | 45 | 7 |
  | 25 | 25 | 6 |
  | 5 | 5 | 5 |
  | -15 | 15 | 4 |
  | -35 | 35 | 3 |
  | -55 | 55 | 2 |
  | -75 | 75 | 1 |
  | -95 | 95 | 0 |

  neg=1 from `in`=-15 onward.
- Bucket boundaries:
  - `in`=19 gives bit 5; 20 gives bit 6.
  - `in`=-19 gives bit 4; -20 gives bit 3.
  - `in`=0 gives bit 5 with neg=0.
- Saturation and clamp:
  - `in`=-32768 gives abs_in=32767, neg=1, bit 0.
  - `in`=32767 gives abs_in=32767, neg=0, bit 9.
  - `in`=-1 gives abs_in=1, neg=1, bit 4.
- Random regression: 10k random `in` values -> board_posit is always one-hot, abs_in always equals |in| (saturated), and all checks are made one cycle after the stimulus.
